// File: rtl/sink_cfg_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sink_cfg_writer
//  Purpose  : Writes a node's sink-designation record (flag, node ID, cleared
//             result word, zeroed data region) into the single-port node
//             memory, then reads the flag back and reports done/error.
//  Revision : 1.0  initial release
// ============================================================================
module sink_cfg_writer #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int CLR_BASE = 3,
    parameter int CLR_LEN  = 8
) (
    input  logic              clock,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic              is_sink,
    input  logic [DATA_W-1:0] node_id,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] address,
    output logic              wr_en,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              error
);

    localparam int                  c_CNT_W    = (CLR_LEN > 0) ? $clog2(CLR_LEN + 1) : 1;
    localparam bit                  c_HAS_CLR  = (CLR_LEN > 0);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = (CLR_LEN > 0) ? c_CNT_W'(CLR_LEN - 1) : '0;
    localparam logic [ADDR_W-1:0]   c_BASE     = ADDR_W'(CLR_BASE);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_FLAG = 4'd1,
        S_WR_ID   = 4'd2,
        S_WR_RES  = 4'd3,
        S_CLR     = 4'd4,
        S_RD_REQ  = 4'd5,
        S_RD_WAIT = 4'd6,
        S_CHECK   = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t              state_q,    state_d;
    logic [c_CNT_W-1:0]  cnt_q,      cnt_d;
    logic                is_sink_q,  is_sink_d;
    logic [DATA_W-1:0]   node_id_q,  node_id_d;
    logic [ADDR_W-1:0]   address_q,  address_d;
    logic                wr_en_q,    wr_en_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                done_q,     done_d;
    logic                error_q,    error_d;

    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic [DATA_W-1:0]   w_flag;

    assign w_cnt_inc = cnt_q + c_CNT_W'(1);
    assign w_flag    = {{(DATA_W-1){1'b0}}, is_sink_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_sink_d  = is_sink_q;
        node_id_d  = node_id_q;
        address_d  = address_q;
        wr_en_d    = wr_en_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        error_d    = error_q;

        if (state_q == S_IDLE) begin
            address_d  = '0;
            wr_en_d    = 1'b0;
            data_out_d = '0;
            done_d     = 1'b0;
            if (en && start) begin
                is_sink_d  = is_sink;
                node_id_d  = node_id;
                error_d    = 1'b0;
                state_d    = S_WR_FLAG;
                wr_en_d    = 1'b1;
                data_out_d = {{(DATA_W-1){1'b0}}, is_sink};
            end
        end else if (state_q == S_DONE) begin
            // en has no say here; only start releases the result
            address_d  = '0;
            wr_en_d    = 1'b0;
            data_out_d = '0;
            done_d     = 1'b1;
            if (!start) begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
        end else if (en) begin
            case (state_q)
                S_WR_FLAG: begin
                    state_d    = S_WR_ID;
                    address_d  = ADDR_W'(1);
                    data_out_d = node_id_q;
                    wr_en_d    = 1'b1;
                end
                S_WR_ID: begin
                    state_d    = S_WR_RES;
                    address_d  = ADDR_W'(2);
                    data_out_d = '0;
                    wr_en_d    = 1'b1;
                end
                S_WR_RES: begin
                    data_out_d = '0;
                    if (c_HAS_CLR) begin
                        state_d   = S_CLR;
                        cnt_d     = '0;
                        address_d = c_BASE;
                        wr_en_d   = 1'b1;
                    end else begin
                        state_d   = S_RD_REQ;
                        address_d = '0;
                        wr_en_d   = 1'b0;
                    end
                end
                S_CLR: begin
                    data_out_d = '0;
                    if (cnt_q == c_CNT_LAST) begin
                        state_d   = S_RD_REQ;
                        address_d = '0;
                        wr_en_d   = 1'b0;
                    end else begin
                        // wraps modulo 2^ADDR_W past the top address
                        cnt_d     = w_cnt_inc;
                        address_d = c_BASE + ADDR_W'(w_cnt_inc);
                        wr_en_d   = 1'b1;
                    end
                end
                S_RD_REQ: begin
                    state_d    = S_RD_WAIT;
                    address_d  = '0;
                    data_out_d = '0;
                    wr_en_d    = 1'b0;
                end
                S_RD_WAIT: begin
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    state_d = S_DONE;
                    error_d = (data_in != w_flag);
                    done_d  = 1'b1;
                end
                default: begin
                    state_d    = S_IDLE;
                    address_d  = '0;
                    wr_en_d    = 1'b0;
                    data_out_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_sink_q  <= 1'b0;
            node_id_q  <= '0;
            address_q  <= '0;
            wr_en_q    <= 1'b0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_sink_q  <= is_sink_d;
            node_id_q  <= node_id_d;
            address_q  <= address_d;
            wr_en_q    <= wr_en_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // The strobe is gated by en so a write presented in a stalled cycle is
    // suppressed and then issued once, unchanged, when en returns.
    assign address  = address_q;
    assign wr_en    = wr_en_q & en;
    assign data_out = data_out_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_sink_cfg_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sink_cfg_writer
//  Purpose  : Scoreboard bench for sink_cfg_writer: three parameterisations,
//             each with its own memory model, checked by a negedge monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sink_cfg_writer;

    localparam int AW = 11;
    localparam int DW = 16;

    typedef struct {
        int inst;
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        int inst;
        int err;
        int cyc;
    } rs_t;

    logic          clock = 1'b0;
    logic          nrst  = 1'b0;
    logic          en        [3];
    logic          start     [3];
    logic          is_sink   [3];
    logic [DW-1:0] node_id   [3];
    logic [DW-1:0] din       [3];
    logic [AW-1:0] addr      [3];
    logic          we        [3];
    logic [DW-1:0] dout      [3];
    logic          done      [3];
    logic          err       [3];
    logic          corrupt   [3];
    logic          done_prev [3];
    logic [DW-1:0] mem [3][2048];

    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    int  t0;
    wr_t wq[$];
    rs_t rq[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sink_cfg_writer u0 (
        .clock(clock), .nrst(nrst), .en(en[0]), .start(start[0]),
        .is_sink(is_sink[0]), .node_id(node_id[0]), .data_in(din[0]),
        .address(addr[0]), .wr_en(we[0]), .data_out(dout[0]),
        .done(done[0]), .error(err[0])
    );

    sink_cfg_writer #(.CLR_LEN(0)) u1 (
        .clock(clock), .nrst(nrst), .en(en[1]), .start(start[1]),
        .is_sink(is_sink[1]), .node_id(node_id[1]), .data_in(din[1]),
        .address(addr[1]), .wr_en(we[1]), .data_out(dout[1]),
        .done(done[1]), .error(err[1])
    );

    sink_cfg_writer #(.CLR_BASE(2045), .CLR_LEN(5)) u2 (
        .clock(clock), .nrst(nrst), .en(en[2]), .start(start[2]),
        .is_sink(is_sink[2]), .node_id(node_id[2]), .data_in(din[2]),
        .address(addr[2]), .wr_en(we[2]), .data_out(dout[2]),
        .done(done[2]), .error(err[2])
    );

    // Single-port memories: write commits at the edge, read data next cycle.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (we[i]) mem[i][addr[i]] <= dout[i];
            din[i] <= (corrupt[i] && addr[i] == '0) ? 16'h8001 : mem[i][addr[i]];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin : mon
        wr_t w;
        rs_t r;
        for (int i = 0; i < 3; i++) begin
            if (we[i]) begin
                chk("wr_expected", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("wr_inst", i, w.inst);
                    chk("wr_addr", int'(addr[i]), w.addr);
                    chk("wr_data", int'(dout[i]), w.data);
                    chk("wr_cycle", cyc, w.cyc);
                end
            end
            if (done[i] && !done_prev[i]) begin
                chk("done_expected", int'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    chk("done_inst", i, r.inst);
                    chk("done_error", int'(err[i]), r.err);
                    chk("done_cycle", cyc, r.cyc);
                end
            end
            done_prev[i] = done[i];
        end
    end

    // Expected write stream for one run; writes with index >= sk are
    // delayed by sn stall cycles.
    task automatic expect_run(input int i, input bit s, input int id, input int len,
                              input int base, input int t, input int sk, input int sn,
                              input int e);
        wr_t w;
        rs_t r;
        for (int k = 1; k <= 3 + len; k++) begin
            w.inst = i;
            w.cyc  = t + k - 1 + ((k >= sk) ? sn : 0);
            case (k)
                1:       begin w.addr = 0; w.data = int'(s); end
                2:       begin w.addr = 1; w.data = id;      end
                3:       begin w.addr = 2; w.data = 0;       end
                default: begin w.addr = (base + k - 4) % 2048; w.data = 0; end
            endcase
            wq.push_back(w);
        end
        r.inst = i;
        r.err  = e;
        r.cyc  = t + 6 + len + sn;
        rq.push_back(r);
    endtask

    // Issues start; t returns the cycle count right after the sampling edge.
    task automatic go(input int i, input bit s, input logic [DW-1:0] id,
                      input bit hold, output int t);
        @(posedge clock); #1;
        is_sink[i] = s;
        node_id[i] = id;
        start[i]   = 1'b1;
        @(posedge clock); #1;
        t = cyc;
        if (!hold) start[i] = 1'b0;
        is_sink[i] = ~s;
        node_id[i] = ~id;
    endtask

    task automatic wait_done(input int i);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clock); #1;
            if (done[i]) seen = 1'b1;
        end
        chk("done_timeout", int'(seen), 1);
    endtask

    task automatic end_run();
        @(negedge clock); #1;
        chk("writes_left", wq.size(), 0);
        chk("results_left", rq.size(), 0);
        wq.delete();
        rq.delete();
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_address"}, int'(addr[i]), 0);
        chk({tag, "_wr_en"},   int'(we[i]),   0);
        chk({tag, "_data"},    int'(dout[i]), 0);
        chk({tag, "_done"},    int'(done[i]), 0);
        chk({tag, "_error"},   int'(err[i]),  0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b1; start[i] = 1'b0; is_sink[i] = 1'b0;
            node_id[i] = '0; corrupt[i] = 1'b0; done_prev[i] = 1'b0;
        end
        nrst = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) chk_zero(i, "reset");
        nrst = 1'b1;

        // nominal sink run, default parameters
        go(0, 1'b1, 16'h00A5, 1'b0, t0);
        expect_run(0, 1'b1, 16'h00A5, 8, 3, t0, 1000, 0, 0);
        wait_done(0);
        end_run();

        // non-sink, no clear phase
        go(1, 1'b0, 16'h0F0F, 1'b0, t0);
        expect_run(1, 1'b0, 16'h0F0F, 0, 3, t0, 1000, 0, 0);
        wait_done(1);
        end_run();

        // corrupted readback, start held so DONE persists
        corrupt[0] = 1'b1;
        go(0, 1'b1, 16'h1111, 1'b1, t0);
        expect_run(0, 1'b1, 16'h1111, 8, 3, t0, 1000, 0, 1);
        wait_done(0);
        repeat (3) begin
            @(posedge clock); #1;
            chk("err_hold", int'(err[0]), 1);
            chk("done_hold", int'(done[0]), 1);
        end
        start[0]   = 1'b0;
        corrupt[0] = 1'b0;
        end_run();

        // clean rerun clears the error
        go(0, 1'b1, 16'h2222, 1'b0, t0);
        expect_run(0, 1'b1, 16'h2222, 8, 3, t0, 1000, 0, 0);
        wait_done(0);
        end_run();

        // three-cycle stall while the clear counter is at 4 (address 7)
        go(0, 1'b1, 16'h0A5A, 1'b0, t0);
        expect_run(0, 1'b1, 16'h0A5A, 8, 3, t0, 8, 3, 0);
        repeat (7) @(posedge clock);
        #1;
        en[0] = 1'b0;
        #1;
        chk("stall_wr_en", int'(we[0]), 0);
        chk("stall_addr", int'(addr[0]), 7);
        repeat (2) begin
            @(posedge clock); #1;
            chk("stall_wr_en", int'(we[0]), 0);
            chk("stall_addr", int'(addr[0]), 7);
        end
        @(posedge clock); #1;
        en[0] = 1'b1;
        wait_done(0);
        end_run();

        // reset during the clear phase, then a full clean run
        go(0, 1'b1, 16'h3333, 1'b0, t0);
        expect_run(0, 1'b1, 16'h3333, 8, 3, t0, 1000, 0, 0);
        repeat (5) @(posedge clock);
        #1;
        chk("pre_reset_pending", wq.size(), 6);
        nrst = 1'b0;
        #1;
        chk_zero(0, "midreset");
        wq.delete();
        rq.delete();
        @(posedge clock); #1;
        nrst = 1'b1;
        go(0, 1'b1, 16'h4444, 1'b0, t0);
        expect_run(0, 1'b1, 16'h4444, 8, 3, t0, 1000, 0, 0);
        wait_done(0);
        end_run();

        // clear region wraps over address 0, so the flag readback mismatches
        go(2, 1'b1, 16'h5555, 1'b0, t0);
        expect_run(2, 1'b1, 16'h5555, 5, 2045, t0, 1000, 0, 1);
        wait_done(2);
        end_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
